// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the frame-sequencer state encoding and the TX output-mux select
// codes. The sequencer, the output mux and the serializer all import these
// so the select encoding lives in exactly one place.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer.
// Accepts a byte request from the host and steps the frame through start,
// data, optional parity and stop phases, one phase step per baud tick.
//
// Ports:
//   CLK               system clock, rising edge
//   RST               synchronous active-high reset
//   TICK              one-cycle baud enable per bit period
//   Data_valid        host request (P_DATA valid while high)
//   PAR_EN            parity enable, captured at frame acceptance
//   PAR_TYPE          parity type (0 even, 1 odd), captured at acceptance
//   ser_load          one-cycle pulse: serializer captures P_DATA
//   ser_en            serializer shift enable (shifts when ser_en & TICK)
//   mux_sel           TX output mux select
//   Enable_Par_Output gates the parity calculator onto its output
//   PAR_TYPE_Q        latched parity type for the parity calculator
//   busy              high from acceptance until the frame completes
//   frame_done        one-cycle pulse on the tick ending the last stop bit
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int STOP_BITS   = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       Data_valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYPE,
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       Enable_Par_Output,
  output logic       PAR_TYPE_Q,
  output logic       busy,
  output logic       frame_done
);

  // One counter serves both the data-bit index and the stop-bit index.
  localparam int CNT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LENGTH - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

  state_t           state_q;
  state_t           state_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic             par_en_q;
  logic             latch_cfg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      par_en_q   <= 1'b0;
      PAR_TYPE_Q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (latch_cfg) begin
        par_en_q   <= PAR_EN;
        PAR_TYPE_Q <= PAR_TYPE;
      end
    end
  end

  always_comb begin
    state_n           = state_q;
    cnt_n             = cnt_q;
    latch_cfg         = 1'b0;
    ser_load          = 1'b0;
    ser_en            = 1'b0;
    mux_sel           = MUX_STOP;
    Enable_Par_Output = 1'b0;
    busy              = 1'b0;
    frame_done        = 1'b0;

    case (state_q)
      IDLE: begin
        // Acceptance ignores TICK; START then waits a full tick period.
        if (Data_valid) begin
          ser_load  = 1'b1;
          latch_cfg = 1'b1;
          cnt_n     = '0;
          state_n   = START;
        end
      end

      START: begin
        mux_sel = MUX_START;
        busy    = 1'b1;
        if (TICK) begin
          cnt_n   = '0;
          state_n = DATA;
        end
      end

      DATA: begin
        mux_sel = MUX_DATA;
        ser_en  = 1'b1;
        busy    = 1'b1;
        if (TICK) begin
          if (cnt_q == DATA_LAST) begin
            cnt_n   = '0;
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end

      PARITY: begin
        mux_sel           = MUX_PAR;
        Enable_Par_Output = 1'b1;
        busy              = 1'b1;
        if (TICK) begin
          cnt_n   = '0;
          state_n = STOP;
        end
      end

      STOP: begin
        mux_sel = MUX_STOP;
        busy    = 1'b1;
        if (TICK) begin
          if (cnt_q == STOP_LAST) begin
            frame_done = 1'b1;
            cnt_n      = '0;
            // A request on the final stop tick chains straight into START.
            if (Data_valid) begin
              ser_load  = 1'b1;
              latch_cfg = 1'b1;
              state_n   = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    // Reset suppresses the Mealy pulses so nothing is loaded or reported
    // on the edge that reset wins.
    if (RST) begin
      ser_load   = 1'b0;
      frame_done = 1'b0;
      latch_cfg  = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl.
// Two instances share the stimulus: u_dut1 has one stop bit, u_dut2 has two.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TICK;
  logic       Data_valid;
  logic       PAR_EN;
  logic       PAR_TYPE;

  logic       ld1, en1, epo1, ptq1, busy1, fd1;
  logic [1:0] mux1;
  logic       ld2, en2, epo2, ptq2, busy2, fd2;
  logic [1:0] mux2;

  int checks = 0;
  int errors = 0;
  int n_ld1, n_fd1, n_ld2, n_fd2;

  logic [1:0] tm1[$];
  logic [1:0] tm2[$];
  logic       tb1[$];
  logic       tp1[$];
  logic       tq1[$];
  logic       tb2[$];
  logic       tl2[$];

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_LENGTH(8), .STOP_BITS(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .Data_valid(Data_valid),
    .PAR_EN(PAR_EN), .PAR_TYPE(PAR_TYPE),
    .ser_load(ld1), .ser_en(en1), .mux_sel(mux1),
    .Enable_Par_Output(epo1), .PAR_TYPE_Q(ptq1),
    .busy(busy1), .frame_done(fd1)
  );

  uart_tx_ctrl #(.DATA_LENGTH(8), .STOP_BITS(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .Data_valid(Data_valid),
    .PAR_EN(PAR_EN), .PAR_TYPE(PAR_TYPE),
    .ser_load(ld2), .ser_en(en2), .mux_sel(mux2),
    .Enable_Par_Output(epo2), .PAR_TYPE_Q(ptq2),
    .busy(busy2), .frame_done(fd2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    n_ld1 = 0; n_fd1 = 0; n_ld2 = 0; n_fd2 = 0;
    tm1.delete(); tm2.delete(); tb1.delete(); tp1.delete();
    tq1.delete(); tb2.delete(); tl2.delete();
  endtask

  // One clock cycle: drive inputs, sample settled outputs, step past the edge.
  task automatic cyc(input logic tk, input logic dv);
    TICK = tk;
    Data_valid = dv;
    #1;
    if (ld1) n_ld1++;
    if (fd1) n_fd1++;
    if (ld2) n_ld2++;
    if (fd2) n_fd2++;
    if (tk) begin
      tm1.push_back(mux1);
      tb1.push_back(busy1);
      tp1.push_back(epo1);
      tq1.push_back(ptq1);
      tm2.push_back(mux2);
      tb2.push_back(busy2);
      tl2.push_back(ld2);
    end
    @(posedge CLK);
    #1;
  endtask

  // One bit period: TICK on the fourth cycle.
  task automatic period(input logic dv);
    repeat (3) cyc(1'b0, dv);
    cyc(1'b1, dv);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    RST = 1'b0;
    clr();
  endtask

  // Plain 8N1 frame on u_dut1: START, 8 DATA, 1 STOP, then one idle tick.
  task automatic check_plain_frame(input string tag);
    int nb;
    check({tag, "_len"}, tm1.size(), 11);
    for (int i = 0; i < 11 && i < tm1.size(); i++) begin
      check($sformatf("%s_mux%0d", tag, i), tm1[i],
            (i == 0) ? 2'b00 : ((i <= 8) ? 2'b10 : 2'b01));
    end
    nb = 0;
    foreach (tb1[i]) if (tb1[i]) nb++;
    check({tag, "_busy_ticks"}, nb, 10);
    check({tag, "_loads"}, n_ld1, 1);
    check({tag, "_done"}, n_fd1, 1);
    check({tag, "_end_mux"}, mux1, 2'b01);
    check({tag, "_end_busy"}, busy1, 1'b0);
  endtask

  initial begin
    int nb;
    RST = 1'b1; TICK = 1'b0; Data_valid = 1'b0; PAR_EN = 1'b0; PAR_TYPE = 1'b0;
    clr();
    @(posedge CLK);
    #1;

    // Reset state; Data_valid high must not load while RST is high.
    cyc(1'b0, 1'b1);
    check("rst_load", ld1, 1'b0);
    check("rst_mux", mux1, 2'b01);
    check("rst_busy", busy1, 1'b0);
    check("rst_ser_en", en1, 1'b0);
    check("rst_par_out", epo1, 1'b0);
    check("rst_ptq", ptq1, 1'b0);
    check("rst_done", fd1, 1'b0);
    check("rst_mux2", mux2, 2'b01);
    check("rst_ser_en2", en2, 1'b0);
    check("rst_par_out2", epo2, 1'b0);
    check("rst_ptq2", ptq2, 1'b0);
    check("rst_load2", ld2, 1'b0);
    RST = 1'b0;
    Data_valid = 1'b0;
    clr();

    // 1: plain frame, no parity
    do_reset();
    PAR_EN = 1'b0;
    cyc(1'b0, 1'b1);
    repeat (11) period(1'b0);
    check_plain_frame("t1");

    // 2: odd parity, settings changed mid-frame
    do_reset();
    PAR_EN = 1'b1; PAR_TYPE = 1'b1;
    cyc(1'b0, 1'b1);
    PAR_EN = 1'b0; PAR_TYPE = 1'b0;
    repeat (12) period(1'b0);
    check("t2_len", tm1.size(), 12);
    if (tm1.size() == 12) begin
      check("t2_mux8", tm1[8], 2'b10);
      check("t2_mux9", tm1[9], 2'b11);
      check("t2_mux10", tm1[10], 2'b01);
      check("t2_par8", tp1[8], 1'b0);
      check("t2_par9", tp1[9], 1'b1);
      check("t2_ptq5", tq1[5], 1'b1);
      check("t2_ptq9", tq1[9], 1'b1);
    end
    nb = 0;
    foreach (tb1[i]) if (tb1[i]) nb++;
    check("t2_busy_ticks", nb, 11);
    check("t2_done", n_fd1, 1);
    check("t2_end_ptq", ptq1, 1'b1);
    PAR_EN = 1'b0; PAR_TYPE = 1'b0;

    // 3: Data_valid held high, two stop bits, back-to-back frames on u_dut2
    do_reset();
    cyc(1'b0, 1'b1);
    repeat (22) period(1'b1);
    check("t3_len", tm2.size(), 22);
    for (int i = 0; i < 22 && i < tm2.size(); i++) begin
      check($sformatf("t3_mux%0d", i), tm2[i],
            ((i % 11) == 0) ? 2'b00 : (((i % 11) <= 8) ? 2'b10 : 2'b01));
    end
    nb = 0;
    foreach (tb2[i]) if (tb2[i]) nb++;
    check("t3_busy_ticks", nb, 22);
    if (tl2.size() == 22) begin
      check("t3_load_t9", tl2[9], 1'b0);
      check("t3_load_t10", tl2[10], 1'b1);
      check("t3_load_t21", tl2[21], 1'b1);
    end
    check("t3_loads", n_ld2, 3);
    check("t3_done", n_fd2, 2);
    check("t3_end_mux", mux2, 2'b00);

    // 4: Data_valid pulsed during DATA is ignored
    do_reset();
    cyc(1'b0, 1'b1);
    repeat (3) period(1'b0);
    period(1'b1);
    repeat (7) period(1'b0);
    check_plain_frame("t4");

    // 5: reset mid-DATA (counter at 3), then a clean frame
    do_reset();
    cyc(1'b0, 1'b1);
    repeat (4) period(1'b0);
    check("t5_pre_mux", mux1, 2'b10);
    RST = 1'b1;
    cyc(1'b0, 1'b0);
    RST = 1'b0;
    check("t5_rst_mux", mux1, 2'b01);
    check("t5_rst_busy", busy1, 1'b0);
    check("t5_rst_ser_en", en1, 1'b0);
    check("t5_rst_par_out", epo1, 1'b0);
    clr();
    cyc(1'b0, 1'b1);
    repeat (11) period(1'b0);
    check_plain_frame("t5");

    // 6: TICK coincident with acceptance does not shorten START
    do_reset();
    cyc(1'b1, 1'b1);
    check("t6_start_mux", mux1, 2'b00);
    check("t6_start_busy", busy1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
    check("t6_hold_mux", mux1, 2'b00);
    cyc(1'b1, 1'b0);
    check("t6_data_mux", mux1, 2'b10);
    check("t6_data_en", en1, 1'b1);
    repeat (10) period(1'b0);
    check("t6_loads", n_ld1, 1);
    check("t6_done", n_fd1, 1);
    check("t6_end_mux", mux1, 2'b01);
    check("t6_end_busy", busy1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmit path. It accepts a byte request, then walks the frame through start, data, optional parity and stop phases, one phase step per baud tick. It drives the serializer load and shift enables, the output-mux select, and the parity calculator's output enable. It sits between the host-side Data_valid handshake and the serializer, parity calculator and TX output mux.

Parameters:
DATA_LENGTH, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
CLK  in  1  system clock; all state changes on its rising edge.
RST  in  1  synchronous, active-high reset.
TICK  in  1  baud enable; one-cycle pulse per bit period.
Data_valid  in  1  host request; P_DATA is valid while this is high.
PAR_EN  in  1  parity enable; sampled only at frame acceptance.
PAR_TYPE  in  1  parity type, 0 = even, 1 = odd; sampled only at frame acceptance.
ser_load  out  1  one-cycle pulse; serializer captures P_DATA.
ser_en  out  1  serializer shifts one bit on each cycle where ser_en and TICK are both high.
mux_sel  out  2  TX output mux select.
Enable_Par_Output  out  1  gates the parity calculator onto its output.
PAR_TYPE_Q  out  1  latched parity type, passed to the parity calculator.
busy  out  1  high from frame acceptance until the frame completes.
frame_done  out  1  one-cycle pulse on the TICK that ends the last stop bit.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. Encoded in 3 bits.
- Reset (RST high at a CLK edge), including mid-frame:
  - state = IDLE; bit counter = 0; PAR_EN_Q = 0; PAR_TYPE_Q = 0.
  - ser_en = 0; mux_sel = MUX_STOP (line idles high); Enable_Par_Output = 0; busy = 0; frame_done = 0.
  - ser_load = 0 while RST is high.
- Acceptance:
  - In IDLE, Data_valid = 1 causes ser_load = 1 in the same cycle (combinational).
  - In that cycle PAR_EN and PAR_TYPE are latched into PAR_EN_Q and PAR_TYPE_Q.
  - Next state is START.
  - Acceptance does not wait for TICK.
- Moore outputs per state:
  - IDLE: mux_sel = MUX_STOP.
  - START: mux_sel = MUX_START, busy = 1.
  - DATA: mux_sel = MUX_DATA, ser_en = 1, busy = 1.
  - PARITY: mux_sel = MUX_PAR, Enable_Par_Output = 1, busy = 1.
  - STOP: mux_sel = MUX_STOP, busy = 1.
- Transitions (all qualified by TICK except acceptance):
  - START -> DATA, and the counter clears to 0.
  - DATA: counter increments on each TICK. When counter = DATA_LENGTH-1, go to PARITY if PAR_EN_Q = 1, otherwise STOP.
  - PARITY -> STOP, and the counter clears.
  - STOP: remains for STOP_BITS ticks. On the final tick frame_done = 1 and the next state is IDLE.
- Back-to-back frames:
  - If Data_valid = 1 on the final STOP tick, the frame is accepted there: ser_load = 1, parity settings are re-latched, next state is START.
  - No idle cycle is inserted between frames.
  - frame_done still pulses on that tick.
- Data_valid while busy (other than the final STOP tick) is ignored. No queuing.
- PAR_EN and PAR_TYPE changes mid-frame have no effect on the current frame.
- TICK arriving in the same cycle as acceptance does not advance START; the start bit always lasts one full TICK period.
- Counter width: $clog2(DATA_LENGTH) bits, with STOP counting sharing the same register. The counter never wraps past DATA_LENGTH-1.
- Illegal or unreachable state encodings return to IDLE on the next edge.

Decomposition:
- Shared package uart_tx_pkg holds:
  - state enum localparams IDLE/START/DATA/PARITY/STOP;
  - mux select constants MUX_START = 2'b00, MUX_STOP = 2'b01, MUX_DATA = 2'b10, MUX_PAR = 2'b11.
  - The mux and the serializer import the same constants.
- One module, no sub-module. The bit counter is inline; splitting it out adds no reuse.

Test Plan:
1. Frame with PAR_EN = 0, DATA_LENGTH = 8, TICK every 4 cycles, Data_valid pulse in IDLE -> ser_load pulses once. mux_sel sequence is 00 (1 tick), 10 (8 ticks), 01 (1 tick). busy is high for exactly 10 ticks. frame_done pulses once, then IDLE.
2. PAR_EN = 1, PAR_TYPE = 1 -> PARITY state appears for 1 tick between DATA and STOP, with mux_sel = 11, Enable_Par_Output = 1 and PAR_TYPE_Q = 1. Toggling PAR_TYPE mid-frame leaves PAR_TYPE_Q unchanged.
3. Data_valid held high continuously, STOP_BITS = 2 -> second ser_load coincides with the final STOP tick. START follows immediately. Exactly 2 STOP ticks per frame; no IDLE between frames.
4. Data_valid pulsed in the DATA state -> no ser_load, no state disturbance, frame length unchanged.
5. RST asserted during DATA at counter = 3 -> on the next edge: IDLE, mux_sel = 01, busy = 0, ser_en = 0. A following Data_valid starts a clean frame with counter = 0.
6. TICK and Data_valid high in the same IDLE cycle -> state is START next cycle. START persists until the next TICK, and DATA starts only after that TICK.
